// File: rtl/timer_ctrl_pkg.sv
// Shared state encodings and default widths for the timer sequencing core.
package timer_ctrl_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PRESC_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: counts enabled cycles and strobes tick when the count matches presc_i.
module timer_prescaler
    import timer_ctrl_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_cnt_reg <= '0;
        end else if (clear) begin
            presc_cnt_reg <= '0;
        end else if (enable) begin
            if (presc_cnt_reg == presc_i)
                presc_cnt_reg <= '0;
            else
                presc_cnt_reg <= presc_cnt_reg + 1'b1;
        end
    end

    // Combinational strobe so the counter advances on the same edge the phase wraps.
    assign tick = enable && (presc_cnt_reg == presc_i);

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing core: FSM, prescaled up-counter, wrap pulse and sticky irq.
// Optional count capture is enabled by defining TIMER_CTRL_CAPTURE_EN.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               TimerRst_i,
    input  logic               TimerEn_i,
    input  logic               oneshot_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic               irq_clr_i,
    input  logic               capture_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               tick_o,
    output logic               wrap_o,
    output logic               irq_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   capture_o
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               tick_reg, wrap_reg, irq_reg;
    logic               irq_next, wrap_hit, terminal;
    logic               run_en, presc_tick;

    assign run_en = (state_reg == ST_RUN) && !TimerRst_i;

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .enable  (run_en),
        .clear   (TimerRst_i),
        .presc_i (presc_i),
        .tick    (presc_tick)
    );

    // >= rather than == so shrinking period_i mid-run wraps at once instead of running away.
    assign terminal = (count_reg >= period_i);
    assign wrap_hit = presc_tick && terminal;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        irq_next   = irq_reg;

        case (state_reg)
            ST_IDLE:  if (TimerEn_i) state_next = ST_RUN;
            ST_RUN: begin
                if (wrap_hit && oneshot_i) state_next = ST_DONE;
                else if (!TimerEn_i)       state_next = ST_PAUSE;
            end
            ST_PAUSE: if (TimerEn_i) state_next = ST_RUN;
            default:  state_next = ST_DONE;
        endcase

        if (presc_tick) begin
            if (!terminal)      count_next = count_reg + 1'b1;
            else if (!oneshot_i) count_next = '0;
        end

        if (TimerRst_i) begin
            state_next = ST_IDLE;
            count_next = '0;
        end

        if (wrap_hit)       irq_next = 1'b1;
        else if (irq_clr_i) irq_next = 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tick_reg  <= presc_tick;
            wrap_reg  <= wrap_hit;
            irq_reg   <= irq_next;
        end
    end

    assign count_o = count_reg;
    assign tick_o  = tick_reg;
    assign wrap_o  = wrap_reg;
    assign irq_o   = irq_reg;
    assign state_o = state_reg;

`ifdef TIMER_CTRL_CAPTURE_EN
    logic             capture_prev_reg;
    logic [CNT_W-1:0] capture_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            capture_prev_reg <= 1'b0;
            capture_reg      <= '0;
        end else begin
            capture_prev_reg <= capture_i;
            if (capture_i && !capture_prev_reg)
                capture_reg <= count_reg;
        end
    end

    assign capture_o = capture_reg;
`else
    logic unused_capture;
    assign unused_capture = capture_i;
    assign capture_o      = '0;
`endif

endmodule
